// File: rtl/param_serializer.sv
// Parametrised parallel-to-serial shifter with IDLE/SHIFT control,
// busy indication and load-time parity for the UART TX path.
module param_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  busy_in,
  input  logic                  par_odd_in,
  input  logic                  ser_en_in,
  output logic                  ser_data,
  output logic                  ser_done_out,
  output logic                  ser_busy_out,
  output logic                  par_bit_out
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam int unsigned OUT_IDX = (MSB_FIRST != 0) ? DATA_WIDTH - 1 : 0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_q, par_d;

  // State, shift register, bit counter and parity registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Load in IDLE, advance one bit per enable in SHIFT, return after last bit
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: begin
        if (data_valid_in && !busy_in) begin
          shreg_d = data_in;
          cnt_d   = '0;
          par_d   = (^data_in) ^ par_odd_in;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en_in) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (MSB_FIRST != 0) begin
              shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registers only
  always_comb begin
    ser_busy_out = (state_q == SHIFT);
    ser_data     = (state_q == SHIFT) ? shreg_q[OUT_IDX] : 1'b0;
    ser_done_out = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    par_bit_out  = par_q;
  end

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: three builds (8 LSB-first,
// 8 MSB-first, 16 LSB-first) share one clock and reset.
module tb_param_serializer;

  typedef struct packed {
    logic d;
    logic done;
    logic par;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] din   [3];
  logic        valid [3];
  logic        binh  [3];
  logic        podd  [3];
  logic        en    [3];
  logic        sd    [3];
  logic        sdone [3];
  logic        sbusy [3];
  logic        spar  [3];

  exp_t q[3][$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb8 (
    .clk(clk), .reset_n(reset_n), .data_in(din[0][7:0]), .data_valid_in(valid[0]),
    .busy_in(binh[0]), .par_odd_in(podd[0]), .ser_en_in(en[0]), .ser_data(sd[0]),
    .ser_done_out(sdone[0]), .ser_busy_out(sbusy[0]), .par_bit_out(spar[0]));

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb8 (
    .clk(clk), .reset_n(reset_n), .data_in(din[1][7:0]), .data_valid_in(valid[1]),
    .busy_in(binh[1]), .par_odd_in(podd[1]), .ser_en_in(en[1]), .ser_data(sd[1]),
    .ser_done_out(sdone[1]), .ser_busy_out(sbusy[1]), .par_bit_out(spar[1]));

  param_serializer #(.DATA_WIDTH(16), .MSB_FIRST(0)) u_lsb16 (
    .clk(clk), .reset_n(reset_n), .data_in(din[2]), .data_valid_in(valid[2]),
    .busy_in(binh[2]), .par_odd_in(podd[2]), .ser_en_in(en[2]), .ser_data(sd[2]),
    .ser_done_out(sdone[2]), .ser_busy_out(sbusy[2]), .par_bit_out(spar[2]));

  task automatic chk(input string name, input int i, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d @%0t: got %b expected %b", name, i, $time, act, exp);
    end
  endtask

  // Monitor: every consumed bit (busy && enable) is checked against the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset_n && sbusy[i] === 1'b1 && en[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          chk("unexpected_bit", i, 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q[i].pop_front();
          chk("ser_data", i, sd[i], e.d);
          chk("ser_done", i, sdone[i], e.done);
          chk("par_bit", i, spar[i], e.par);
        end
      end
    end
  end

  // Load one word, push its expected bits, clock it out with optional gaps
  // and optional junk loads held through SHIFT and the done edge.
  task automatic run_word(input int i, input logic [15:0] data, input logic po,
                          input logic exp_par, input bit gaps, input bit junk);
    int w;
    int n;
    int cyc;
    bit msbf;
    exp_t e;
    w = (i == 2) ? 16 : 8;
    msbf = (i == 1);
    for (int k = 0; k < w; k++) begin
      e.d    = msbf ? data[w-1-k] : data[k];
      e.done = (k == w - 1);
      e.par  = exp_par;
      q[i].push_back(e);
    end
    din[i] = data;
    podd[i] = po;
    valid[i] = 1'b1;
    @(posedge clk); #1;
    valid[i] = junk;
    din[i] = junk ? 16'hFFFF : data;
    podd[i] = ~po;
    chk("busy_after_load", i, sbusy[i], 1'b1);
    n = 0;
    cyc = 0;
    while (n < w && cyc < 200) begin
      en[i] = gaps ? pat[cyc % 7] : 1'b1;
      @(posedge clk);
      if (en[i]) n++;
      cyc++;
      #1;
    end
    if (cyc >= 200) chk("enable_budget", i, 1'b0, 1'b1);
    en[i] = 1'b0;
    valid[i] = 1'b0;
    chk("idle_after_done", i, sbusy[i], 1'b0);
    chk("done_low_idle", i, sdone[i], 1'b0);
    chk("par_hold", i, spar[i], exp_par);
    chk("queue_drained", i, (q[i].size() == 0), 1'b1);
    @(posedge clk); #1;
    chk("no_late_load", i, sbusy[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; valid[i] = 1'b0; binh[i] = 1'b0; podd[i] = 1'b0; en[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", i, sd[i], 1'b0);
      chk("rst_done", i, sdone[i], 1'b0);
      chk("rst_busy", i, sbusy[i], 1'b0);
      chk("rst_par", i, spar[i], 1'b0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic word, LSB first, even parity
    run_word(0, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    // MSB first, odd parity
    run_word(1, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b0);
    run_word(1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    // Enable gaps
    run_word(0, 16'h003C, 1'b0, 1'b0, 1'b1, 1'b0);
    run_word(1, 16'h00C1, 1'b1, 1'b0, 1'b1, 1'b0);
    // Loads during SHIFT and on the done edge are ignored
    run_word(0, 16'h0096, 1'b1, 1'b1, 1'b0, 1'b1);
    // Wide word
    run_word(2, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_word(2, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0);

    // Inhibit blocks loading
    din[0] = 16'h00FF; valid[0] = 1'b1; binh[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("inhibit_no_load", 0, sbusy[0], 1'b0);
    end
    valid[0] = 1'b0; binh[0] = 1'b0;

    // Reset mid-word: first three bits consumed, then abort
    begin
      exp_t e;
      logic [7:0] v;
      v = 8'hA5;
      for (int k = 0; k < 3; k++) begin
        e.d = v[k]; e.done = 1'b0; e.par = 1'b0;
        q[0].push_back(e);
      end
    end
    din[0] = 16'h00A5; podd[0] = 1'b0; valid[0] = 1'b1;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    en[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    en[0] = 1'b0;
    chk("pre_reset_busy", 0, sbusy[0], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data", 0, sd[0], 1'b0);
    chk("mid_rst_done", 0, sdone[0], 1'b0);
    chk("mid_rst_busy", 0, sbusy[0], 1'b0);
    chk("mid_rst_par", 0, spar[0], 1'b0);
    chk("mid_rst_queue", 0, (q[0].size() == 0), 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      en[0] = c[0];
      @(posedge clk); #1;
      chk("no_resume", 0, sbusy[0], 1'b0);
    end
    en[0] = 1'b0;

    // Post-reset fresh load still works
    run_word(0, 16'h0081, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) chk("final_queue_empty", i, (q[i].size() == 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
# param_serializer

Parametrised parallel-to-serial shifter. It is the next-generation replacement for the fixed 8-bit LSB-first serializer in the UART TX path of the multi-clock system. It adds:
- configurable word width and bit order;
- an explicit IDLE/SHIFT state machine with a busy indication;
- a parity bit computed at load time.

It sits between the TX FIFO/sync stage and the TX frame FSM, which drives `ser_en_in` one cycle per bit.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, word width in bits; legal range 2..32.
- `MSB_FIRST`, default 0. 0 shifts bit 0 out first; 1 shifts bit `DATA_WIDTH-1` out first.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `data_in`  in  `DATA_WIDTH`  parallel word to serialise.
- `data_valid_in`  in  1  `data_in` valid; qualifies a load.
- `busy_in`  in  1  external inhibit; no load while high.
- `par_odd_in`  in  1  parity type sampled at load: 0 even, 1 odd.
- `ser_en_in`  in  1  advance one bit (from the frame FSM).
- `ser_data`  out  1  current serial bit.
- `ser_done_out`  out  1  high while the last bit is presented.
- `ser_busy_out`  out  1  high in SHIFT.
- `par_bit_out`  out  1  parity of the most recently loaded word.

## Operation
- Internal state:
  - `shreg[DATA_WIDTH-1:0]`, the shift register;
  - `cnt`, width `$clog2(DATA_WIDTH)`;
  - `par_q`, the registered parity;
  - state `IDLE`/`SHIFT`.
- **IDLE**:
  - Load when `data_valid_in && !busy_in`. On the load edge:
    - `shreg <= data_in`
    - `cnt <= 0`
    - `par_q <= ^data_in ^ par_odd_in`
    - state goes to SHIFT.
  - `ser_en_in` is ignored.
- **SHIFT**:
  - `ser_en_in=1` and `cnt < DATA_WIDTH-1`:
    - `cnt <= cnt+1`
    - `shreg` shifts right, zero-filled, if `MSB_FIRST=0`; otherwise shifts left, zero-filled.
  - `ser_en_in=1` and `cnt == DATA_WIDTH-1`: `cnt <= 0`, state goes to IDLE. `shreg` contents are don't-care afterwards.
  - `ser_en_in=0`: hold all state. Gaps of any length are legal.
  - `data_valid_in` is ignored. There is no reload mid-word, and no load on the edge that leaves SHIFT.
- Outputs:
  - `ser_data`: combinational. In SHIFT it is `shreg[0]` (`MSB_FIRST=0`) or `shreg[DATA_WIDTH-1]` (`MSB_FIRST=1`); in IDLE it is 0.
  - `ser_done_out`: combinational, `(state==SHIFT) && (cnt==DATA_WIDTH-1)`. The frame FSM uses it to move to the parity/stop bit on the same edge it consumes the last data bit.
  - `ser_busy_out`: `(state==SHIFT)`.
  - `par_bit_out = par_q`. It is stable from the cycle after load until the next load, so the frame FSM reads it after `ser_done_out`.
- Counter never wraps past `DATA_WIDTH-1`. For non-power-of-2 widths the unused counter codes are unreachable.
- Reset values (asynchronous, immediate):
  - state IDLE, `cnt=0`, `shreg=0`, `par_q=0`;
  - hence `ser_data=0`, `ser_done_out=0`, `ser_busy_out=0`, `par_bit_out=0`.
- Reset mid-word aborts the word. Nothing resumes after release; the next word needs a fresh load.

## Timing
- Load latency: if `data_valid_in` is accepted at edge N, the first bit appears on `ser_data` and `ser_busy_out=1` from just after edge N.
- Each edge with `ser_en_in=1` in SHIFT presents the next bit.
- With `ser_en_in` held high from cycle N+1, the word occupies exactly `DATA_WIDTH` cycles:
  - `ser_done_out` is high in the last one (cycle N+`DATA_WIDTH`);
  - IDLE is reached after edge N+`DATA_WIDTH`.
- The earliest next load is the edge after returning to IDLE. Minimum spacing between accepted loads is `DATA_WIDTH+1` cycles.
- No combinational path from `data_in` or `data_valid_in` to any output. `ser_data` and `ser_done_out` depend only on registers.

## Test plan
- **Reset:** assert `reset_n=0` mid-SHIFT → all outputs 0 immediately. After release, `ser_en_in` pulses with no load keep `ser_busy_out=0`.
- **Basic word:** `DATA_WIDTH=8`, `MSB_FIRST=0`, load `0xA5`, `par_odd_in=0`, `ser_en_in` continuous →
  - `ser_data` sequence 1,0,1,0,0,1,0,1;
  - `ser_done_out` high only on the 8th bit;
  - `par_bit_out=0`;
  - IDLE one edge after done.
- **MSB first, odd parity:** `MSB_FIRST=1`, load `0xA5`, `par_odd_in=1` → sequence 1,0,1,0,0,1,0,1 (MSB first) and `par_bit_out=1`. Load `0x01` → 0,0,0,0,0,0,0,1 and `par_bit_out=0`.
- **Enable gaps:** `ser_en_in` pattern 1,0,0,1,1,0,1… → each bit is held through gaps, and exactly 8 enables complete the word.
- **Load rules:**
  - `data_valid_in` pulsed with new data during SHIFT and on the done edge → ignored; the original word completes.
  - Load with `busy_in=1` → no load.
- **Wide word:** `DATA_WIDTH=16` build, load `0x8001`, continuous enable → 1, then fourteen 0s, then 1. `ser_done_out` on the 16th bit; `par_bit_out=0`.
